// File: rtl/button_conditioner_if.sv
// Pin-side and strobe-side signals of the button conditioner.
// The slave side is the conditioner itself; the master side drives the pins
// and consumes the strobes.
interface button_conditioner_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] raw_i;
  logic [CHANNELS-1:0] level_o;
  logic [CHANNELS-1:0] press_o;
  logic [CHANNELS-1:0] release_o;
  logic [CHANNELS-1:0] long_press_o;
  logic [CHANNELS-1:0] repeat_o;
  logic                sys_reset_o;

  modport master (
    output raw_i,
    input  level_o, press_o, release_o, long_press_o, repeat_o, sys_reset_o
  );

  modport slave (
    input  raw_i,
    output level_o, press_o, release_o, long_press_o, repeat_o, sys_reset_o
  );
endinterface

// File: rtl/button_conditioner.sv
// Multi-channel push-button front end: 2-FF synchroniser, debounce counter,
// press/release/long-press/auto-repeat strobes and a stretched system reset
// driven by power-on and by a long press on RESET_CH.
module button_conditioner #(
  parameter int          CHANNELS      = 4,
  parameter bit          ACTIVE_LOW    = 1'b1,
  parameter logic [15:0] DEBOUNCE      = 16'h0fff,
  parameter logic [23:0] LONG_CYCLES   = 24'd4_000_000,
  parameter logic [23:0] REPEAT_CYCLES = 24'd1_000_000,
  parameter int          RESET_CH      = 0,
  parameter logic [15:0] RESET_STRETCH = 16'h0fff
) (
  input logic                 clk,
  input logic                 rst,
  button_conditioner_if.slave bus
);

  localparam int             DW      = $clog2(DEBOUNCE) + 1;
  localparam logic [DW-1:0]  DB_LAST = DW'(DEBOUNCE - 16'd1);
  localparam logic [23:0]    HOLD_MAX = 24'hff_ffff;

  logic [CHANNELS-1:0] level_vec;
  logic [CHANNELS-1:0] press_vec;
  logic [CHANNELS-1:0] release_vec;
  logic [CHANNELS-1:0] long_vec;
  logic [CHANNELS-1:0] repeat_vec;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic          p;
    logic          s1_q, s2_q;
    logic          level_q, level_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [23:0]   hold_q, hold_d;
    logic [23:0]   rep_q, rep_d, rep_inc;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;
    logic          rpt_q, rpt_d;

    assign p       = ACTIVE_LOW ? ~bus.raw_i[gi] : bus.raw_i[gi];
    assign rep_inc = rep_q + 24'd1;

    // Debounce, hold and repeat next-state; hold/repeat follow the level being
    // registered this edge so the press cycle already counts as hold = 1.
    always_comb begin
      level_d   = level_q;
      cnt_d     = cnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (s2_q == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == DB_LAST) begin
        level_d   = s2_q;
        cnt_d     = '0;
        press_d   = s2_q;
        release_d = ~s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end

      if (!level_d)              hold_d = '0;
      else if (hold_q == HOLD_MAX) hold_d = hold_q;
      else                       hold_d = hold_q + 24'd1;

      long_d = level_d && (hold_d == LONG_CYCLES);

      // Repeat counting only runs once the long press has already fired;
      // in the long-press cycle itself rep is cleared.
      rep_d = '0;
      rpt_d = 1'b0;
      if (level_d && (hold_q >= LONG_CYCLES) && (REPEAT_CYCLES != 24'd0)) begin
        if (rep_inc == REPEAT_CYCLES) begin
          rpt_d = 1'b1;
          rep_d = '0;
        end else begin
          rep_d = rep_inc;
        end
      end
    end

    // Per-channel state and registered strobes.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_q      <= 1'b0;
        s2_q      <= 1'b0;
        level_q   <= 1'b0;
        cnt_q     <= '0;
        hold_q    <= '0;
        rep_q     <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        rpt_q     <= 1'b0;
      end else begin
        s1_q      <= p;
        s2_q      <= s1_q;
        level_q   <= level_d;
        cnt_q     <= cnt_d;
        hold_q    <= hold_d;
        rep_q     <= rep_d;
        press_q   <= press_d;
        release_q <= release_d;
        long_q    <= long_d;
        rpt_q     <= rpt_d;
      end
    end

    assign level_vec[gi]   = level_q;
    assign press_vec[gi]   = press_q;
    assign release_vec[gi] = release_q;
    assign long_vec[gi]    = long_q;
    assign repeat_vec[gi]  = rpt_q;
  end

  typedef enum logic {ST_HOLD, ST_RUN} rst_state_e;

  rst_state_e  state_q;
  logic [15:0] stretch_q;
  logic        sys_reset_q;
  logic        reset_trig;

  assign reset_trig = long_vec[RESET_CH];

  // Reset stretcher: hold sys_reset for RESET_STRETCH cycles; a long press on
  // the reset channel (re)starts the pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_HOLD;
      stretch_q   <= RESET_STRETCH - 16'd1;
      sys_reset_q <= 1'b1;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (reset_trig) begin
            stretch_q <= RESET_STRETCH - 16'd1;
          end else if (stretch_q == 16'd0) begin
            state_q     <= ST_RUN;
            sys_reset_q <= 1'b0;
          end else begin
            stretch_q <= stretch_q - 16'd1;
          end
        end
        ST_RUN: begin
          if (reset_trig) begin
            state_q     <= ST_HOLD;
            stretch_q   <= RESET_STRETCH - 16'd1;
            sys_reset_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_HOLD;
          stretch_q   <= RESET_STRETCH - 16'd1;
          sys_reset_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.level_o      = level_vec;
  assign bus.press_o      = press_vec;
  assign bus.release_o    = release_vec;
  assign bus.long_press_o = long_vec;
  assign bus.repeat_o     = repeat_vec;
  assign bus.sys_reset_o  = sys_reset_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Randomised and directed bench for button_conditioner. A window-based
// reference model pushes the expected outputs of every clock edge into a
// queue; a monitor on the falling edge pops and compares.
module tb_button_conditioner;

  localparam int CH = 2;
  localparam int DB = 4;
  localparam int LC = 20;
  localparam int RC = 5;
  localparam int RS = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  button_conditioner_if #(.CHANNELS(CH)) bus ();

  button_conditioner #(
    .CHANNELS(CH), .ACTIVE_LOW(1'b1), .DEBOUNCE(16'd4), .LONG_CYCLES(24'd20),
    .REPEAT_CYCLES(24'd5), .RESET_CH(0), .RESET_STRETCH(16'd8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CH-1:0] level;
    logic [CH-1:0] press;
    logic [CH-1:0] rel;
    logic [CH-1:0] lng;
    logic [CH-1:0] rpt;
    logic          sys;
  } exp_t;

  exp_t expq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, req);
    end
  endtask

  function automatic exp_t reset_exp();
    exp_t e;
    e.level = '0; e.press = '0; e.rel = '0; e.lng = '0; e.rpt = '0; e.sys = 1'b1;
    return e;
  endfunction

  // Reference model state: recent pressed-samples per channel, accepted
  // level, length of the current pressed run, and the last edge index
  // for which sys_reset must still be high.
  bit hist [CH][8];
  bit mlevel [CH];
  int run_len [CH];
  int k;
  int high_until;

  // A channel's level flips once the synchronised input (two edges late) has
  // disagreed with it for DB consecutive samples. Long press / repeat come
  // from the run length of the pressed level.
  task automatic model_step();
    exp_t          e;
    logic [CH-1:0] pv;
    bit            flip;
    if (rst) begin
      for (int c = 0; c < CH; c++) begin
        for (int j = 0; j < 8; j++) hist[c][j] = 1'b0;
        mlevel[c]  = 1'b0;
        run_len[c] = 0;
      end
      k          = 0;
      high_until = RS - 1;
      e          = reset_exp();
    end else begin
      k++;
      pv    = ~bus.raw_i;
      e.sys = (k <= high_until);
      for (int c = 0; c < CH; c++) begin
        for (int j = 7; j > 0; j--) hist[c][j] = hist[c][j-1];
        hist[c][0] = pv[c];
        flip = 1'b1;
        for (int j = 2; j <= DB + 1; j++)
          if (hist[c][j] == mlevel[c]) flip = 1'b0;
        e.press[c] = 1'b0;
        e.rel[c]   = 1'b0;
        if (flip) begin
          mlevel[c]  = ~mlevel[c];
          e.press[c] = mlevel[c];
          e.rel[c]   = ~mlevel[c];
        end
        run_len[c] = mlevel[c] ? run_len[c] + 1 : 0;
        e.level[c] = mlevel[c];
        e.lng[c]   = mlevel[c] && (run_len[c] == LC);
        e.rpt[c]   = mlevel[c] && (RC != 0) && (run_len[c] > LC) &&
                     (((run_len[c] - LC) % RC) == 0);
      end
      if (e.lng[0] && (k + RS > high_until)) high_until = k + RS;
    end
    expq.push_back(e);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Monitor: one expected entry per edge; while reset is asserted the
  // outputs must already sit at their reset values.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() != 0) begin
        e = expq.pop_front();
        if (rst) e = reset_exp();
        chk("level",      32'(bus.level_o),      32'(e.level));
        chk("press",      32'(bus.press_o),      32'(e.press));
        chk("release",    32'(bus.release_o),    32'(e.rel));
        chk("long_press", 32'(bus.long_press_o), 32'(e.lng));
        chk("repeat",     32'(bus.repeat_o),     32'(e.rpt));
        chk("sys_reset",  32'(bus.sys_reset_o),  32'(e.sys));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int cd [CH];
    bus.raw_i = 2'b11;
    rst       = 1'b1;
    $display("phase power-on reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(15);

    $display("phase clean press ch1");
    bus.raw_i[1] = 1'b0;
    idle(46);
    bus.raw_i[1] = 1'b1;
    idle(20);

    $display("phase bounce then long hold ch0 (reset channel)");
    for (int i = 0; i < 10; i++) begin
      bus.raw_i[0] = ~bus.raw_i[0];
      idle(2);
    end
    bus.raw_i[0] = 1'b0;
    idle(45);
    bus.raw_i[0] = 1'b1;
    idle(20);

    $display("phase glitch ch1");
    bus.raw_i[1] = 1'b0;
    idle(3);
    bus.raw_i[1] = 1'b1;
    idle(15);

    $display("phase reset mid-count ch1");
    bus.raw_i[1] = 1'b0;
    idle(20);
    #1 rst = 1'b1;
    #1;
    chk("rst_now_level",     32'(bus.level_o),      32'd0);
    chk("rst_now_press",     32'(bus.press_o),      32'd0);
    chk("rst_now_release",   32'(bus.release_o),    32'd0);
    chk("rst_now_long",      32'(bus.long_press_o), 32'd0);
    chk("rst_now_repeat",    32'(bus.repeat_o),     32'd0);
    chk("rst_now_sys_reset", 32'(bus.sys_reset_o),  32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(40);
    bus.raw_i[1] = 1'b1;
    idle(20);

    $display("phase random stimulus");
    for (int c = 0; c < CH; c++) cd[c] = 0;
    for (int i = 0; i < 800; i++) begin
      for (int c = 0; c < CH; c++) begin
        if (cd[c] == 0) begin
          bus.raw_i[c] = 1'($urandom_range(0, 1));
          cd[c]        = $urandom_range(1, 30);
        end else begin
          cd[c]--;
        end
      end
      idle(1);
    end
    bus.raw_i = 2'b11;
    idle(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
